inst_mem_responder: RTL and testbench
=====================================

INST_MEM_RESPONDER -- requirements
Module: inst_mem_responder

Interface
REQ-001 The block SHALL take parameter DEPTH_LOG2, default 8: instruction memory holds 2^DEPTH_LOG2 32-bit words.
REQ-002 The block SHALL take parameter WAIT_CYCLES, default 1, legal range 1..15: fetch-response latency in cycles.
REQ-003 The block SHALL use reset resetn, synchronous, active-low, and clock clk.
REQ-004 Ports SHALL be:
  clk  in  1  clock
  resetn  in  1  synchronous active-low reset
  req_valid  in  1  fetch request valid
  req_addr  in  32  byte fetch address
  req_ready  out  1  request accepted this cycle when high with req_valid
  resp_valid  out  1  response valid
  resp_ready  in  1  requester consumes response
  resp_inst  out  32  fetched instruction
  resp_err  out  1  misaligned or out-of-range address
  load_start  in  1  pulse: begin program load at word 0
  load_stop  in  1  pulse: end program load
  load_valid  in  1  load byte valid
  load_byte  in  8  program byte, little-endian
  load_ready  out  1  load byte accepted when high with load_valid
  load_wptr  out  DEPTH_LOG2  next word index to be written

Function
REQ-005 FSM states SHALL be IDLE, BUSY and RESP, with IDLE after reset.
REQ-006 req_ready SHALL be high only in IDLE with load_active low; it SHALL be decoded from registered state only, with no combinational path from req_valid.
REQ-007 Request acceptance (req_valid and req_ready at an edge) SHALL latch req_addr, load the wait counter with WAIT_CYCLES-1 and enter BUSY.
REQ-008 BUSY SHALL decrement the counter each cycle; at zero it SHALL register the result and enter RESP, so that resp_valid rises exactly WAIT_CYCLES edges after the accepting edge.
REQ-009 Result: if addr[1:0]!=0 or addr[31:2] >= 2^DEPTH_LOG2, resp_err SHALL be 1 and resp_inst SHALL be 0; otherwise resp_err SHALL be 0 and resp_inst SHALL be mem[addr[DEPTH_LOG2+1:2]].
REQ-010 In RESP, resp_valid, resp_inst and resp_err SHALL stay stable until resp_ready is high at an edge; that edge SHALL drop resp_valid and return to IDLE.
REQ-011 A new request SHALL NOT be accepted in the same cycle as a response is consumed; the earliest new acceptance is the next cycle.
REQ-012 load_start SHALL set load_active, clear the byte index and clear load_wptr.
REQ-013 load_stop SHALL clear load_active and discard any partial word.
REQ-014 If load_start and load_stop arrive in the same cycle, load_stop SHALL win.
REQ-015 load_start SHALL take effect in any FSM state; an in-flight fetch SHALL complete normally.
REQ-016 load_ready SHALL be high only when load_active is high and the FSM is in IDLE.
REQ-017 Each accepted load byte SHALL fill byte lane [8*i+7:8*i] of the assembly register, where i is the byte index 0..3.
REQ-018 On the fourth accepted byte, the block SHALL write the assembled word to mem[load_wptr] in that same edge, then increment load_wptr and reset the byte index to 0.
REQ-019 load_wptr SHALL wrap from 2^DEPTH_LOG2-1 to 0.
REQ-020 The memory array SHALL be a synchronous single-write-port array; a fetch read of the word written in the same cycle is not possible, because reads occur only while load_active is low.

Reset
REQ-021 When resetn is low at an edge, the block SHALL set the FSM to IDLE, resp_valid=0, resp_inst=0, resp_err=0, load_active=0, byte index=0 and load_wptr=0.
REQ-022 Reset SHALL abort any in-flight fetch without producing a response and SHALL discard any partial load word.
REQ-023 Memory contents SHALL NOT be reset.
REQ-024 After reset release, req_ready SHALL be 1 and load_ready SHALL be 0.

Verification
REQ-025 Load: load_start, then bytes 13,00,01,24,FF,FF,02,24, then load_stop -> mem[0]=24010013, mem[1]=2402FFFF, load_wptr=2.
REQ-026 Fetch with WAIT_CYCLES=1 and resp_ready held 1: req_addr=4 accepted at edge N -> resp_valid=1 after edge N+1 with resp_inst=2402FFFF; req_ready=1 again after edge N+2.
REQ-027 Backpressure with WAIT_CYCLES=3 and resp_ready=0 for 5 cycles: resp_valid rises 3 edges after acceptance, and resp_inst stays stable for all 5 cycles until consumed.
REQ-028 Errors: req_addr=0x2 gives resp_err=1 and resp_inst=0; req_addr=0x400 with DEPTH_LOG2=8 gives resp_err=1.
REQ-029 Partial load and wrap: 6 bytes then load_stop -> only one word written, load_wptr=1; loading 256 full words gives load_wptr=0.
REQ-030 Reset mid-operation: resetn low while in BUSY -> no response ever issues, resp_valid=0; memory still returns previously loaded data afterwards.

Source files
------------

// File: rtl/inst_mem_responder.sv
// Instruction memory responder: byte-serial program loader plus a
// single-outstanding fetch port with a fixed, programmable response latency.
module inst_mem_responder #(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_valid,
    input  logic [31:0]           req_addr,
    output logic                  req_ready,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_inst,
    output logic                  resp_err,
    input  logic                  load_start,
    input  logic                  load_stop,
    input  logic                  load_valid,
    input  logic [7:0]            load_byte,
    output logic                  load_ready,
    output logic [DEPTH_LOG2-1:0] load_wptr
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [3:0]            wait_cnt;
    logic [31:0]           addr_q;
    logic                  load_active;
    logic [1:0]            byte_idx;
    // Only the lower three byte lanes are held; the fourth byte goes
    // straight from load_byte into the memory write.
    logic [23:0]           asm_q;
    logic [31:0]           mem [DEPTH];

    logic                  req_fire;
    logic                  load_fire;
    logic                  busy_done;

    // A fetch address is bad if misaligned or beyond the last word.
    function automatic logic addr_is_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> (DEPTH_LOG2 + 2)) != 32'd0);
    endfunction

    // Handshake qualifiers are decoded from registered state only.
    assign req_ready  = (state == IDLE) && !load_active;
    assign resp_valid = (state == RESP);
    assign load_ready = load_active && (state == IDLE);
    assign req_fire   = req_valid && req_ready;
    // start/stop pulses own the cycle; a byte offered alongside them is ignored.
    assign load_fire  = load_valid && load_ready && !load_start && !load_stop;
    assign busy_done  = (state == BUSY) && (wait_cnt == 4'd0);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: accept -> wait out latency -> hold response until consumed.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_fire)   state_nxt = BUSY;
            BUSY:    if (busy_done)  state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the fetch address at acceptance.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            addr_q <= req_addr;
        end
    end

    // Latency counter: loaded with WAIT_CYCLES-1, counts down while BUSY.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wait_cnt <= 4'd0;
        end else if (req_fire) begin
            wait_cnt <= 4'(WAIT_CYCLES - 1);
        end else if ((state == BUSY) && (wait_cnt != 4'd0)) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Response register: captured once when the wait expires, then held.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            resp_inst <= 32'd0;
            resp_err  <= 1'b0;
        end else if (busy_done) begin
            if (addr_is_bad(addr_q)) begin
                resp_inst <= 32'd0;
                resp_err  <= 1'b1;
            end else begin
                resp_inst <= mem[addr_q[DEPTH_LOG2+1:2]];
                resp_err  <= 1'b0;
            end
        end
    end

    // Loader control: stop beats start, start rewinds to word 0.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            load_active <= 1'b0;
            byte_idx    <= 2'd0;
            load_wptr   <= '0;
        end else if (load_stop) begin
            load_active <= 1'b0;
            byte_idx    <= 2'd0;
        end else if (load_start) begin
            load_active <= 1'b1;
            byte_idx    <= 2'd0;
            load_wptr   <= '0;
        end else if (load_fire) begin
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
                load_wptr <= load_wptr + 1'b1;
            end
        end
    end

    // Little-endian word assembly of the first three bytes.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            case (byte_idx)
                2'd0:    asm_q[7:0]   <= load_byte;
                2'd1:    asm_q[15:8]  <= load_byte;
                2'd2:    asm_q[23:16] <= load_byte;
                default: ;
            endcase
        end
    end

    // Memory write on the fourth byte; contents survive reset.
    always_ff @(posedge clk) begin
        if (load_fire && (byte_idx == 2'd3)) begin
            mem[load_wptr] <= {load_byte, asm_q};
        end
    end

endmodule

// File: tb/tb_inst_mem_responder.sv
// Bench for inst_mem_responder: two instances (latency 1 and 3) share
// stimulus; a byte-queue memory model predicts every fetch result.
module tb_inst_mem_responder;

    localparam int DL2   = 8;
    localparam int DEPTH = 1 << DL2;
    localparam int WA    = 1;
    localparam int WB    = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           resetn, req_valid, load_start, load_stop, load_valid;
    logic           rr_a, rr_b;
    logic [31:0]    req_addr;
    logic [7:0]     load_byte;
    logic           a_req_ready, a_resp_valid, a_resp_err, a_load_ready;
    logic [31:0]    a_resp_inst;
    logic [DL2-1:0] a_wptr;
    logic           b_req_ready, b_resp_valid, b_resp_err, b_load_ready;
    logic [31:0]    b_resp_inst;
    logic [DL2-1:0] b_wptr;

    inst_mem_responder #(.DEPTH_LOG2(DL2), .WAIT_CYCLES(WA)) dut_a (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(a_req_ready),
        .resp_valid(a_resp_valid), .resp_ready(rr_a),
        .resp_inst(a_resp_inst), .resp_err(a_resp_err),
        .load_start(load_start), .load_stop(load_stop),
        .load_valid(load_valid), .load_byte(load_byte),
        .load_ready(a_load_ready), .load_wptr(a_wptr)
    );

    inst_mem_responder #(.DEPTH_LOG2(DL2), .WAIT_CYCLES(WB)) dut_b (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(b_req_ready),
        .resp_valid(b_resp_valid), .resp_ready(rr_b),
        .resp_inst(b_resp_inst), .resp_err(b_resp_err),
        .load_start(load_start), .load_stop(load_stop),
        .load_valid(load_valid), .load_byte(load_byte),
        .load_ready(b_load_ready), .load_wptr(b_wptr)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] ref_mem [DEPTH];
    int          ref_wptr;
    logic [7:0]  ref_bytes [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected {err, inst} for a byte address, from the addressing rules.
    function automatic logic [32:0] ref_fetch(input logic [31:0] a);
        if ((a % 4) != 0 || (a / 4) >= DEPTH) return {1'b1, 32'h0};
        return {1'b0, ref_mem[a / 4]};
    endfunction

    task automatic ld_pulse(input bit start, input bit stop);
        load_start = start;
        load_stop  = stop;
        step();
        load_start = 1'b0;
        load_stop  = 1'b0;
        if (stop) begin
            ref_bytes.delete();
        end else if (start) begin
            ref_bytes.delete();
            ref_wptr = 0;
        end
    endtask

    task automatic ld_byte(input logic [7:0] b);
        chk("a_load_ready", a_load_ready, 1);
        chk("b_load_ready", b_load_ready, 1);
        load_valid = 1'b1;
        load_byte  = b;
        step();
        load_valid = 1'b0;
        ref_bytes.push_back(b);
        if (ref_bytes.size() == 4) begin
            ref_mem[ref_wptr] = {ref_bytes[3], ref_bytes[2], ref_bytes[1], ref_bytes[0]};
            ref_wptr = (ref_wptr + 1) % DEPTH;
            ref_bytes.delete();
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        ref_bytes.delete();
        ref_wptr = 0;
    endtask

    // One fetch on both instances; instance b holds resp_ready low for 'hold' cycles.
    task automatic fetch(input logic [31:0] addr, input int hold);
        logic [32:0] e;
        bit a_got, a_done, b_got, b_done, rr_prev;
        int b_held;
        e = ref_fetch(addr);
        a_got = 0; a_done = 0; b_got = 0; b_done = 0; b_held = 0;
        chk("a_req_ready_idle", a_req_ready, 1);
        chk("b_req_ready_idle", b_req_ready, 1);
        req_valid = 1'b1;
        req_addr  = addr;
        rr_a      = 1'b1;
        rr_b      = 1'b0;
        step();
        req_valid = 1'b0;
        req_addr  = $urandom();
        chk("a_req_ready_busy", a_req_ready, 0);
        chk("b_req_ready_busy", b_req_ready, 0);
        chk("a_resp_valid_early", a_resp_valid, 0);
        for (int k = 1; k <= 40 && !(a_done && b_done); k++) begin
            rr_prev = rr_b;
            step();
            if (a_got && !a_done) begin
                chk("a_resp_valid_consumed", a_resp_valid, 0);
                chk("a_req_ready_after", a_req_ready, 1);
                a_done = 1;
            end else if (!a_got && a_resp_valid) begin
                chk("a_latency", k, WA);
                chk("a_resp_inst", a_resp_inst, e[31:0]);
                chk("a_resp_err", a_resp_err, e[32]);
                a_got = 1;
            end
            if (b_got && !b_done) begin
                if (rr_prev) begin
                    chk("b_resp_valid_consumed", b_resp_valid, 0);
                    chk("b_req_ready_after", b_req_ready, 1);
                    b_done = 1;
                end else begin
                    chk("b_resp_valid_held", b_resp_valid, 1);
                    chk("b_resp_inst_held", b_resp_inst, e[31:0]);
                    chk("b_resp_err_held", b_resp_err, e[32]);
                    b_held++;
                end
            end else if (!b_got && b_resp_valid) begin
                chk("b_latency", k, WB);
                chk("b_resp_inst", b_resp_inst, e[31:0]);
                chk("b_resp_err", b_resp_err, e[32]);
                b_got = 1;
            end
            if (b_got && !b_done) rr_b = (b_held >= hold);
        end
        chk("a_fetch_complete", a_done, 1);
        chk("b_fetch_complete", b_done, 1);
        rr_b = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  prog [8];
        logic [31:0] ra;
        resetn = 1'b0; req_valid = 1'b0; req_addr = 32'd0;
        load_start = 1'b0; load_stop = 1'b0; load_valid = 1'b0; load_byte = 8'd0;
        rr_a = 1'b0; rr_b = 1'b0; ref_wptr = 0;
        prog[0] = 8'h13; prog[1] = 8'h00; prog[2] = 8'h01; prog[3] = 8'h24;
        prog[4] = 8'hFF; prog[5] = 8'hFF; prog[6] = 8'h02; prog[7] = 8'h24;
        repeat (3) step();
        resetn = 1'b1;
        step();

        // Reset state
        chk("rst_a_req_ready", a_req_ready, 1);
        chk("rst_b_req_ready", b_req_ready, 1);
        chk("rst_a_load_ready", a_load_ready, 0);
        chk("rst_b_load_ready", b_load_ready, 0);
        chk("rst_a_resp_valid", a_resp_valid, 0);
        chk("rst_a_resp_inst", a_resp_inst, 0);
        chk("rst_a_resp_err", a_resp_err, 0);
        chk("rst_a_wptr", a_wptr, 0);

        // Two-word program load
        ld_pulse(1, 0);
        chk("load_blocks_req", a_req_ready, 0);
        for (int i = 0; i < 8; i++) ld_byte(prog[i]);
        ld_pulse(0, 1);
        chk("prog_a_wptr", a_wptr, ref_wptr);
        chk("prog_b_wptr", b_wptr, ref_wptr);
        chk("prog_wptr_two", a_wptr, 2);
        chk("stop_a_load_ready", a_load_ready, 0);

        // Fetches, backpressure, errors
        fetch(32'h4, 0);
        chk("prog_word1", a_resp_inst, 32'h2402FFFF);
        fetch(32'h0, 5);
        chk("prog_word0", b_resp_inst, 32'h24010013);
        fetch(32'h2, 0);
        fetch(32'h400, 1);

        // Partial load: six bytes write only one word
        ld_pulse(1, 0);
        for (int i = 0; i < 6; i++) ld_byte(8'($urandom()));
        ld_pulse(0, 1);
        chk("partial_a_wptr", a_wptr, 1);
        chk("partial_b_wptr", b_wptr, ref_wptr);
        fetch(32'h0, 0);
        fetch(32'h4, 2);

        // Simultaneous start and stop: stop wins, pointer untouched
        ld_pulse(1, 1);
        chk("startstop_load_ready", a_load_ready, 0);
        chk("startstop_req_ready", b_req_ready, 1);
        chk("startstop_wptr", a_wptr, 1);

        // Full memory load wraps the write pointer
        ld_pulse(1, 0);
        for (int w = 0; w < DEPTH; w++) begin
            for (int j = 0; j < 4; j++) ld_byte(8'($urandom()));
            if (w == DEPTH / 2) chk("mid_wptr", a_wptr, ref_wptr);
        end
        chk("wrap_a_wptr", a_wptr, 0);
        chk("wrap_b_wptr", b_wptr, ref_wptr);
        ld_pulse(0, 1);

        // Randomized fetches against the model
        repeat (24) begin
            case ($urandom_range(0, 3))
                0, 1:    ra = 32'($urandom_range(0, DEPTH - 1)) * 4;
                2:       ra = (32'($urandom_range(0, DEPTH - 1)) * 4) | 32'($urandom_range(1, 3));
                default: ra = $urandom();
            endcase
            fetch(ra, $urandom_range(0, 4));
        end
        fetch(32'h3FC, 3);

        // Reset while both instances are BUSY aborts the fetch
        rr_a = 1'b0; rr_b = 1'b0;
        req_valid = 1'b1; req_addr = 32'h8;
        step();
        req_valid = 1'b0;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            chk("abort_a_resp_valid", a_resp_valid, 0);
            chk("abort_b_resp_valid", b_resp_valid, 0);
            step();
        end
        chk("abort_a_req_ready", a_req_ready, 1);
        fetch(32'h8, 1);

        // Reset discards a partial load word and clears the loader
        ld_pulse(1, 0);
        for (int i = 0; i < 3; i++) ld_byte(8'($urandom()));
        do_reset();
        chk("rst_partial_load_ready", a_load_ready, 0);
        chk("rst_partial_wptr", b_wptr, 0);
        fetch(32'h0, 0);
        fetch(32'h10, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
